uop_mem_port: RTL and testbench

- Downstream of the micro-op execute stage; consumes its mar_wr / mem_rq / mem_rq_cmd / mem_rq_width strobes.
- Owns the memory address register (MAR) and sequences 8- or 16-bit reads and writes over the 8-bit external bus.
- Drives `stop` back to the execute stage to stall it while a bus transaction is in flight.
- Returns read data with a valid pulse and reports bus timeouts.

---
 rtl/uop_mem_port_pkg.sv | 16 +
 rtl/uop_mem_port_if.sv | 21 ++
 rtl/uop_mem_port_timeout.sv | 42 ++++
 rtl/uop_mem_port.sv | 188 ++++++++++++++++++
 tb/tb_uop_mem_port.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uop_mem_port_pkg.sv
// Shared definitions for the micro-op memory port: FSM encoding and
// command/width strobe values as produced by the execute stage.
package uop_mem_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } mem_state_e;

    localparam logic MEM_CMD_READ  = 1'b0;
    localparam logic MEM_CMD_WRITE = 1'b1;
    localparam logic MEM_W8        = 1'b0;
    localparam logic MEM_W16       = 1'b1;

endpackage

// File: rtl/uop_mem_port_if.sv
// 8-bit external memory bus; the port is master, the memory is slave.
interface uop_mem_port_if;

    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/uop_mem_port_timeout.sv
// Per-beat wait counter: cleared on beat entry, counts cycles without ack and
// flags expiry on the cycle the count would reach TIMEOUT.
module uop_mem_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic a_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/uop_mem_port.sv
// Micro-op memory port: owns the MAR, sequences 8/16-bit accesses over an
// 8-bit bus, stalls the execute stage and reports read data and timeouts.
module uop_mem_port
    import uop_mem_port_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  a_rst,
    input  logic                  mar_wr,
    input  logic [15:0]           mar_in,
    input  logic                  mem_rq,
    input  logic                  mem_rq_cmd,
    input  logic                  mem_rq_width,
    input  logic [15:0]           wr_data,
    uop_mem_port_if.master        bus,
    output logic                  stop,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic                  bus_err,
    output logic [15:0]           mar
);

    mem_state_e  state_d, state_q;
    logic [15:0] mar_d, mar_q;
    logic [15:0] base_d, base_q;
    logic        cmd_d, cmd_q;
    logic        width_d, width_q;
    logic [15:0] wdata_d, wdata_q;
    logic [15:0] rd_data_d, rd_data_q;
    logic        rd_valid_d, rd_valid_q;
    logic        bus_err_d, bus_err_q;
    logic        bus_req_d, bus_req_q;
    logic        bus_we_d, bus_we_q;
    logic [15:0] bus_addr_d, bus_addr_q;
    logic [7:0]  bus_wdata_d, bus_wdata_q;
    logic        stop_d, stop_q;
    logic        tmo_clr, tmo_en, tmo_expired;

    uop_mem_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk     (clk),
        .a_rst   (a_rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Sequencer: next state, transaction latches and read capture.
    always_comb begin
        state_d    = state_q;
        mar_d      = mar_wr ? mar_in : mar_q;
        base_d     = base_q;
        cmd_d      = cmd_q;
        width_d    = width_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        tmo_clr    = 1'b0;
        tmo_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_rq) begin
                    state_d = ST_BEAT0;
                    base_d  = mar_wr ? mar_in : mar_q;
                    cmd_d   = mem_rq_cmd;
                    width_d = mem_rq_width;
                    wdata_d = wr_data;
                    tmo_clr = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                tmo_en = !bus.bus_ack;
                if (bus.bus_ack) begin
                    if (cmd_q == MEM_CMD_READ) begin
                        // An 8-bit read zero-extends into the upper byte.
                        rd_data_d = (width_q == MEM_W16) ? {rd_data_q[15:8], bus.bus_rdata}
                                                         : {8'h00, bus.bus_rdata};
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    if (width_q == MEM_W16) begin
                        state_d = ST_BEAT1;
                        tmo_clr = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        rd_valid_d = (cmd_q == MEM_CMD_READ);
                    end
                end else if (tmo_expired) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BEAT1: begin
                tmo_en = !bus.bus_ack;
                if (bus.bus_ack) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = (cmd_q == MEM_CMD_READ);
                    if (cmd_q == MEM_CMD_READ) begin
                        rd_data_d = {bus.bus_rdata, rd_data_q[7:0]};
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else if (tmo_expired) begin
                    state_d   = ST_IDLE;
                    bus_err_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus-side outputs are registered from the next state so they line up with it.
    always_comb begin
        stop_d    = (state_d != ST_IDLE);
        bus_req_d = (state_d != ST_IDLE);
        bus_we_d  = (state_d != ST_IDLE) && (cmd_d == MEM_CMD_WRITE);
        case (state_d)
            ST_BEAT0: begin
                bus_addr_d  = base_d;
                bus_wdata_d = wdata_d[7:0];
            end
            ST_BEAT1: begin
                bus_addr_d  = base_d + 16'd1;
                bus_wdata_d = wdata_d[15:8];
            end
            default: begin
                bus_addr_d  = bus_addr_q;
                bus_wdata_d = bus_wdata_q;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q     <= ST_IDLE;
            mar_q       <= 16'h0000;
            base_q      <= 16'h0000;
            cmd_q       <= 1'b0;
            width_q     <= 1'b0;
            wdata_q     <= 16'h0000;
            rd_data_q   <= 16'h0000;
            rd_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 16'h0000;
            bus_wdata_q <= 8'h00;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mar_q       <= mar_d;
            base_q      <= base_d;
            cmd_q       <= cmd_d;
            width_q     <= width_d;
            wdata_q     <= wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            bus_err_q   <= bus_err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            stop_q      <= stop_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign stop          = stop_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign bus_err       = bus_err_q;
    assign mar           = mar_q;

endmodule

// File: tb/tb_uop_mem_port.sv
// Directed bench for uop_mem_port; the memory side is driven by hand per beat.
module tb_uop_mem_port;

    logic        clk = 1'b0;
    logic        a_rst = 1'b0;
    logic        mar_wr = 1'b0;
    logic [15:0] mar_in = 16'h0000;
    logic        mem_rq = 1'b0;
    logic        mem_rq_cmd = 1'b0;
    logic        mem_rq_width = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        stop, rd_valid, bus_err;
    logic [15:0] rd_data, mar;

    int n_checks = 0;
    int n_fail = 0;
    int stop_cnt = 0;
    int rdv_cnt = 0;
    int err_cnt = 0;

    uop_mem_port_if bus ();

    uop_mem_port #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk          (clk),
        .a_rst        (a_rst),
        .mar_wr       (mar_wr),
        .mar_in       (mar_in),
        .mem_rq       (mem_rq),
        .mem_rq_cmd   (mem_rq_cmd),
        .mem_rq_width (mem_rq_width),
        .wr_data      (wr_data),
        .bus          (bus),
        .stop         (stop),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .bus_err      (bus_err),
        .mar          (mar)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (stop === 1'b1) stop_cnt++;
        if (rd_valid === 1'b1) rdv_cnt++;
        if (bus_err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic cmd, input logic width, input logic [15:0] wd);
        mem_rq = 1'b1; mem_rq_cmd = cmd; mem_rq_width = width; wr_data = wd;
        tick();
        mem_rq = 1'b0; mar_wr = 1'b0;
    endtask

    // Sample the beat, wait `waits` cycles, then ack with rdata for one cycle.
    task automatic serve_beat(input logic [7:0] rdata, input int waits,
                              output logic req, output logic [15:0] addr,
                              output logic we, output logic [7:0] wdata);
        req = bus.bus_req; addr = bus.bus_addr; we = bus.bus_we; wdata = bus.bus_wdata;
        for (int i = 0; i < waits; i++) begin
            tick();
            mem_rq = 1'b0;
        end
        bus.bus_rdata = rdata; bus.bus_ack = 1'b1;
        tick();
        mem_rq = 1'b0; bus.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.bus_ack = 1'b0; bus.bus_rdata = 8'h00;
        #2;
        n_checks++;
        if ({bus.bus_req, bus.bus_we, stop, rd_valid, bus_err} !== 5'b0 ||
            bus.bus_addr !== 16'h0000 || bus.bus_wdata !== 8'h00 ||
            rd_data !== 16'h0000 || mar !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b we=%b stop=%b addr=%h wd=%h rd=%h mar=%h required all zero",
                     bus.bus_req, bus.bus_we, stop, bus.bus_addr, bus.bus_wdata, rd_data, mar);
        end
        tick();
        a_rst = 1'b1;
        tick();
    endtask

    task automatic test_read16();
        logic r, we; logic [15:0] a; logic [7:0] wd; int s0, v0;
        mar_wr = 1'b1; mar_in = 16'h1234;
        tick();
        mar_wr = 1'b0;
        n_checks++;
        if (mar !== 16'h1234) begin n_fail++; $display("FAIL mar_load got=%h required=1234", mar); end
        s0 = stop_cnt; v0 = rdv_cnt;
        issue(1'b0, 1'b1, 16'h0000);
        serve_beat(8'hCD, 0, r, a, we, wd);
        n_checks++;
        if (r !== 1'b1 || a !== 16'h1234 || we !== 1'b0) begin
            n_fail++; $display("FAIL rd16_beat0 got req=%b addr=%h we=%b required 1/1234/0", r, a, we);
        end
        serve_beat(8'hAB, 0, r, a, we, wd);
        n_checks++;
        if (r !== 1'b1 || a !== 16'h1235) begin
            n_fail++; $display("FAIL rd16_beat1 got req=%b addr=%h required 1/1235", r, a);
        end
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hABCD || stop !== 1'b0) begin
            n_fail++; $display("FAIL rd16_done got valid=%b data=%h stop=%b required 1/ABCD/0", rd_valid, rd_data, stop);
        end
        tick();
        n_checks++;
        if (stop_cnt - s0 != 2 || rdv_cnt - v0 != 1) begin
            n_fail++; $display("FAIL rd16_counts got stop=%0d valid=%0d required 2/1", stop_cnt - s0, rdv_cnt - v0);
        end
    endtask

    task automatic test_write8_bypass();
        logic r, we; logic [15:0] a; logic [7:0] wd; int s0, v0;
        s0 = stop_cnt; v0 = rdv_cnt;
        mar_wr = 1'b1; mar_in = 16'h0040;
        issue(1'b1, 1'b0, 16'h55AA);
        serve_beat(8'h00, 0, r, a, we, wd);
        n_checks++;
        if (r !== 1'b1 || a !== 16'h0040 || we !== 1'b1 || wd !== 8'hAA) begin
            n_fail++; $display("FAIL wr8_beat got req=%b addr=%h we=%b wd=%h required 1/0040/1/AA", r, a, we, wd);
        end
        tick();
        n_checks++;
        if (stop_cnt - s0 != 1 || rdv_cnt - v0 != 0 || mar !== 16'h0040 || bus.bus_we !== 1'b0) begin
            n_fail++; $display("FAIL wr8_after got stop=%0d valid=%0d mar=%h we=%b required 1/0/0040/0",
                               stop_cnt - s0, rdv_cnt - v0, mar, bus.bus_we);
        end
    endtask

    task automatic test_wrap();
        logic r, we; logic [15:0] a; logic [7:0] wd;
        mar_wr = 1'b1; mar_in = 16'hFFFF;
        tick();
        mar_wr = 1'b0;
        issue(1'b1, 1'b1, 16'hBEEF);
        serve_beat(8'h00, 0, r, a, we, wd);
        n_checks++;
        if (a !== 16'hFFFF || wd !== 8'hEF || we !== 1'b1) begin
            n_fail++; $display("FAIL wrap_beat0 got addr=%h wd=%h we=%b required FFFF/EF/1", a, wd, we);
        end
        serve_beat(8'h00, 0, r, a, we, wd);
        n_checks++;
        if (a !== 16'h0000 || wd !== 8'hBE || we !== 1'b1) begin
            n_fail++; $display("FAIL wrap_beat1 got addr=%h wd=%h we=%b required 0000/BE/1", a, wd, we);
        end
        n_checks++;
        if (rd_data !== 16'hABCD || rd_valid !== 1'b0 || bus.bus_addr !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_hold got rd=%h valid=%b addr=%h required ABCD/0/0000", rd_data, rd_valid, bus.bus_addr);
        end
        tick();
    endtask

    task automatic test_wait_states();
        logic r, we; logic [15:0] a; logic [7:0] wd; int s0, v0;
        mar_wr = 1'b1; mar_in = 16'h2000;
        tick();
        mar_wr = 1'b0;
        s0 = stop_cnt; v0 = rdv_cnt;
        issue(1'b0, 1'b1, 16'h0000);
        mem_rq = 1'b1; mem_rq_cmd = 1'b1; mem_rq_width = 1'b0;
        serve_beat(8'h76, 3, r, a, we, wd);
        serve_beat(8'h98, 3, r, a, we, wd);
        n_checks++;
        if (a !== 16'h2001) begin n_fail++; $display("FAIL wait_beat1_addr got=%h required=2001", a); end
        n_checks++;
        if (rd_data !== 16'h9876 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL wait_data got rd=%h valid=%b required 9876/1", rd_data, rd_valid);
        end
        tick(); tick(); tick();
        n_checks++;
        if (stop_cnt - s0 != 8 || rdv_cnt - v0 != 1 || stop !== 1'b0) begin
            n_fail++; $display("FAIL wait_counts got stop=%0d valid=%0d stop_now=%b required 8/1/0",
                               stop_cnt - s0, rdv_cnt - v0, stop);
        end
    endtask

    task automatic test_timeout();
        logic r, we; logic [15:0] a; logic [7:0] wd; int e0, v0, s0;
        e0 = err_cnt; v0 = rdv_cnt; s0 = stop_cnt;
        issue(1'b0, 1'b0, 16'h0000);
        tick(); tick(); tick();
        n_checks++;
        if (stop !== 1'b1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_early got stop=%b err=%b required 1/0", stop, bus_err);
        end
        tick();
        n_checks++;
        if (stop !== 1'b0 || bus_err !== 1'b1 || bus.bus_req !== 1'b0) begin
            n_fail++; $display("FAIL tmo_fire got stop=%b err=%b req=%b required 0/1/0", stop, bus_err, bus.bus_req);
        end
        tick();
        n_checks++;
        if (err_cnt - e0 != 1 || rdv_cnt - v0 != 0 || stop_cnt - s0 != 4 || rd_data !== 16'h9876) begin
            n_fail++; $display("FAIL tmo_after got err=%0d valid=%0d stop=%0d rd=%h required 1/0/4/9876",
                               err_cnt - e0, rdv_cnt - v0, stop_cnt - s0, rd_data);
        end
        e0 = err_cnt; v0 = rdv_cnt;
        issue(1'b0, 1'b0, 16'h0000);
        serve_beat(8'h5A, 3, r, a, we, wd);
        tick();
        n_checks++;
        if (err_cnt - e0 != 0 || rdv_cnt - v0 != 1 || rd_data !== 16'h005A) begin
            n_fail++; $display("FAIL tmo_ack_wins got err=%0d valid=%0d rd=%h required 0/1/005A",
                               err_cnt - e0, rdv_cnt - v0, rd_data);
        end
    endtask

    task automatic test_reset_mid_beat();
        logic r, we; logic [15:0] a; logic [7:0] wd; int e0, v0;
        mar_wr = 1'b1; mar_in = 16'h3000;
        tick();
        mar_wr = 1'b0;
        issue(1'b0, 1'b1, 16'h0000);
        serve_beat(8'h11, 0, r, a, we, wd);
        e0 = err_cnt; v0 = rdv_cnt;
        #2 a_rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.bus_req, bus.bus_we, stop, rd_valid, bus_err} !== 5'b0 ||
            bus.bus_addr !== 16'h0000 || rd_data !== 16'h0000 || mar !== 16'h0000) begin
            n_fail++; $display("FAIL rst_mid got req=%b stop=%b addr=%h rd=%h mar=%h required zeros",
                               bus.bus_req, stop, bus.bus_addr, rd_data, mar);
        end
        tick(); tick();
        a_rst = 1'b1;
        tick();
        issue(1'b0, 1'b0, 16'h0000);
        serve_beat(8'h7E, 0, r, a, we, wd);
        n_checks++;
        if (a !== 16'h0000 || rd_data !== 16'h007E || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_fresh_read got addr=%h rd=%h valid=%b required 0000/007E/1", a, rd_data, rd_valid);
        end
        tick();
        n_checks++;
        if (err_cnt - e0 != 0 || rdv_cnt - v0 != 1) begin
            n_fail++; $display("FAIL rst_counts got err=%0d valid=%0d required 0/1", err_cnt - e0, rdv_cnt - v0);
        end
    endtask

    initial begin
        test_reset();
        test_read16();
        test_write8_bypass();
        test_wrap();
        test_wait_states();
        test_timeout();
        test_reset_mid_beat();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
